// File: rtl/sb_mem_pkg.sv
// Shared types and limits for the simple_bus memory target.
package sb_mem_pkg;
  typedef enum logic [1:0] {
    SB_RD       = 2'b00,
    SB_WR       = 2'b01,
    SB_BURST_RD = 2'b10,
    SB_RSVD     = 2'b11
  } sb_mode_e;

  typedef enum logic [1:0] {IDLE, GRANTED, WAIT, BEAT} sb_state_e;

  localparam int MAX_WAIT  = 15;
  localparam int MAX_BURST = 16;
endpackage

// File: rtl/sb_mem_target_array.sv
// Single-port word array: synchronous write, combinational read.
module sb_mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

// File: rtl/sb_mem_target.sv
// simple_bus memory target: req/gnt arbitration handshake, programmable wait
// states, wrapping burst reads and error beats for bad mode/address.
module sb_mem_target import sb_mem_pkg::*; #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1,
  parameter int BURST_LEN   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  output logic              gnt,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdy,
  output logic              err
);
  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      WAIT_LD  = 4'(WAIT_CYCLES);
  localparam logic [4:0]      BURST_LD = 5'(BURST_LEN);

  if (DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("sb_mem_target: DEPTH exceeds 2**ADDR_W");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
    $error("sb_mem_target: WAIT_CYCLES out of range 0..15");
  end
  if (BURST_LEN < 2 || BURST_LEN > MAX_BURST) begin : g_bad_burst
    $error("sb_mem_target: BURST_LEN out of range 2..16");
  end

  sb_state_e         state;
  sb_mode_e          cur_mode;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              cur_err;
  logic [3:0]        wcnt;
  logic [4:0]        bcnt;

  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;
  logic [ADDR_W:0]   addr_inc;
  logic [ADDR_W-1:0] addr_nxt;
  logic              start_err;

  // Increment one bit wider so DEPTH == 2**ADDR_W still wraps cleanly.
  assign addr_inc  = {1'b0, cur_addr} + (ADDR_W+1)'(1);
  assign addr_nxt  = (addr_inc >= DEPTH_X) ? '0 : addr_inc[ADDR_W-1:0];
  assign start_err = (mode == SB_RSVD) || ({1'b0, addr} >= DEPTH_X);
  assign mem_we    = (state == BEAT) && (cur_mode == SB_WR) && !cur_err;

  sb_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (cur_addr[IDX_W-1:0]),
    .wdata (cur_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      rdy       <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      wcnt      <= '0;
      bcnt      <= '0;
      cur_mode  <= SB_RD;
      cur_addr  <= '0;
      cur_wdata <= '0;
      cur_err   <= 1'b0;
    end else begin
      rdy <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (req) begin
          gnt   <= 1'b1;
          state <= GRANTED;
        end
        GRANTED: begin
          if (start) begin
            cur_mode  <= sb_mode_e'(mode);
            cur_addr  <= addr;
            cur_wdata <= wdata;
            cur_err   <= start_err;
            wcnt      <= WAIT_LD;
            bcnt      <= (mode == SB_BURST_RD && !start_err) ? BURST_LD : 5'd1;
            state     <= (WAIT_CYCLES == 0) ? BEAT : WAIT;
          end else if (!req) begin
            gnt   <= 1'b0;
            state <= IDLE;
          end
        end
        WAIT: begin
          wcnt <= (wcnt != 0) ? wcnt - 4'd1 : 4'd0;
          if (wcnt <= 4'd1) state <= BEAT;
        end
        BEAT: begin
          rdy   <= 1'b1;
          err   <= cur_err;
          rdata <= (cur_err || cur_mode == SB_WR) ? '0 : mem_rdata;
          bcnt  <= (bcnt != 0) ? bcnt - 5'd1 : 5'd0;
          if (bcnt > 5'd1) begin
            cur_addr <= addr_nxt;
            wcnt     <= WAIT_LD;
            state    <= (WAIT_CYCLES == 0) ? BEAT : WAIT;
          end else if (req) begin
            state <= GRANTED;
          end else begin
            gnt   <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          gnt   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sb_mem_target.sv
// Two targets (DEPTH 256 and 200) share one stimulus stream; each is checked
// against a transaction-level memory model with per-beat timing.
module tb_sb_mem_target;
  localparam int W = 2;

  logic       clk, rst_n, req, start;
  logic [1:0] mode;
  logic [7:0] addr, wdata;
  logic       gnt_a, rdy_a, err_a, gnt_b, rdy_b, err_b;
  logic [7:0] rdata_a, rdata_b;

  sb_mem_target #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(W), .BURST_LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_a), .start(start), .mode(mode),
    .addr(addr), .wdata(wdata), .rdata(rdata_a), .rdy(rdy_a), .err(err_a));

  sb_mem_target #(.ADDR_W(8), .DATA_W(8), .DEPTH(200), .WAIT_CYCLES(W), .BURST_LEN(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_b), .start(start), .mode(mode),
    .addr(addr), .wdata(wdata), .rdata(rdata_b), .rdy(rdy_b), .err(err_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic e; } beat_t;
  typedef struct {
    logic [1:0] m; logic [7:0] a, wd;
    logic [7:0] exp_a; logic err_a; logic [7:0] exp_b; logic err_b;
  } vec_t;

  logic [7:0] ma [256];
  logic [7:0] mb [200];
  beat_t      qa [$];
  beat_t      qb [$];
  logic [7:0] beats_a [$];
  int         checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input bit sel, input beat_t x);
    if (sel) qb.push_back(x); else qa.push_back(x);
  endtask

  // Expected beats for one command on the target with the given depth.
  task automatic model(input bit sel, input logic [1:0] m, input logic [7:0] a, input logic [7:0] wd);
    int    depth, n, ad;
    beat_t x;
    depth = sel ? 200 : 256;
    if (m == 2'b11 || int'(a) >= depth) begin
      x.d = 8'h00; x.e = 1'b1; push(sel, x);
    end else if (m == 2'b01) begin
      if (sel) mb[a] = wd; else ma[a] = wd;
      x.d = 8'h00; x.e = 1'b0; push(sel, x);
    end else begin
      n = (m == 2'b10) ? 4 : 1;
      for (int i = 0; i < n; i++) begin
        ad  = (int'(a) + i) % depth;
        x.d = sel ? mb[ad] : ma[ad];
        x.e = 1'b0;
        push(sel, x);
      end
    end
  endtask

  task automatic do_txn(input logic [1:0] m, input logic [7:0] a, input logic [7:0] wd,
                        input int drop_at, input int stray_at,
                        output logic [7:0] ra, output logic ea,
                        output logic [7:0] rb, output logic eb);
    int    cyc, ka, kb, t;
    beat_t x;
    ra = 0; ea = 0; rb = 0; eb = 0;
    beats_a = {};
    req = 1'b1;
    t = 0;
    while (!(gnt_a && gnt_b) && t < 20) begin @(negedge clk); t++; end
    chk("grant", {31'd0, gnt_a & gnt_b}, 32'd1);
    model(1'b0, m, a, wd);
    model(1'b1, m, a, wd);
    mode = m; addr = a; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; ka = 0; kb = 0;
    while ((qa.size() != 0 || qb.size() != 0) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (rdy_a) begin
        if (qa.size() == 0) chk("extra_beat_a", 32'd1, 32'd0);
        else begin
          x = qa.pop_front();
          chk("latency_a", cyc, (ka + 1) * (W + 1));
          chk("rdata_a", {24'd0, rdata_a}, {24'd0, x.d});
          chk("err_a", {31'd0, err_a}, {31'd0, x.e});
          ka++; ra = rdata_a; ea = err_a;
          beats_a.push_back(rdata_a);
        end
      end
      if (rdy_b) begin
        if (qb.size() == 0) chk("extra_beat_b", 32'd1, 32'd0);
        else begin
          x = qb.pop_front();
          chk("latency_b", cyc, (kb + 1) * (W + 1));
          chk("rdata_b", {24'd0, rdata_b}, {24'd0, x.d});
          chk("err_b", {31'd0, err_b}, {31'd0, x.e});
          kb++; rb = rdata_b; eb = err_b;
        end
      end
      if (cyc == drop_at) req = 1'b0;
      if (cyc == stray_at) begin
        start = 1'b1; mode = 2'b01; addr = 8'h20; wdata = 8'hEE;
      end
    end
    chk("beats_left_a", qa.size(), 32'd0);
    chk("beats_left_b", qb.size(), 32'd0);
  endtask

  vec_t       tbl [8];
  logic [7:0] ra, rb;
  logic       ea, eb;
  logic [7:0] last_a;

  initial begin
    tbl[0] = '{2'b01, 8'h10, 8'hA5, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{2'b00, 8'h10, 8'h00, 8'hA5, 1'b0, 8'hA5, 1'b0};
    tbl[2] = '{2'b01, 8'hD2, 8'h5A, 8'h00, 1'b0, 8'h00, 1'b1};
    tbl[3] = '{2'b00, 8'hD2, 8'h00, 8'h5A, 1'b0, 8'h00, 1'b1};
    tbl[4] = '{2'b11, 8'h10, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    tbl[5] = '{2'b00, 8'h10, 8'h00, 8'hA5, 1'b0, 8'hA5, 1'b0};
    tbl[6] = '{2'b01, 8'hC7, 8'h3C, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[7] = '{2'b00, 8'hC7, 8'h00, 8'h3C, 1'b0, 8'h3C, 1'b0};

    // Reset with req held high
    rst_n = 1'b0; req = 1'b1; start = 1'b0; mode = 2'b00; addr = 8'h00; wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_gnt_a", {31'd0, gnt_a}, 32'd0);
    chk("rst_rdy_a", {31'd0, rdy_a}, 32'd0);
    chk("rst_err_a", {31'd0, err_a}, 32'd0);
    chk("rst_rdata_a", {24'd0, rdata_a}, 32'd0);
    chk("rst_gnt_b", {31'd0, gnt_b}, 32'd0);
    chk("rst_rdata_b", {24'd0, rdata_b}, 32'd0);
    rst_n = 1'b1;
    #1 chk("gnt_at_release", {31'd0, gnt_a}, 32'd0);
    @(negedge clk);
    chk("gnt_after_release_a", {31'd0, gnt_a}, 32'd1);
    chk("gnt_after_release_b", {31'd0, gnt_b}, 32'd1);

    // Prefill every location so later reads are defined
    for (int i = 0; i < 256; i++)
      do_txn(2'b01, 8'(i), 8'($urandom), -1, -1, ra, ea, rb, eb);

    for (int i = 0; i < 8; i++) begin
      do_txn(tbl[i].m, tbl[i].a, tbl[i].wd, -1, -1, ra, ea, rb, eb);
      chk($sformatf("tbl%0d_rdata_a", i), {24'd0, ra}, {24'd0, tbl[i].exp_a});
      chk($sformatf("tbl%0d_err_a", i), {31'd0, ea}, {31'd0, tbl[i].err_a});
      chk($sformatf("tbl%0d_rdata_b", i), {24'd0, rb}, {24'd0, tbl[i].exp_b});
      chk($sformatf("tbl%0d_err_b", i), {31'd0, eb}, {31'd0, tbl[i].err_b});
    end

    // Wrapping burst on the 256-deep target
    do_txn(2'b01, 8'hFE, 8'h11, -1, -1, ra, ea, rb, eb);
    do_txn(2'b01, 8'hFF, 8'h22, -1, -1, ra, ea, rb, eb);
    do_txn(2'b01, 8'h00, 8'h33, -1, -1, ra, ea, rb, eb);
    do_txn(2'b01, 8'h01, 8'h44, -1, -1, ra, ea, rb, eb);
    do_txn(2'b10, 8'hFE, 8'h00, -1, -1, ra, ea, rb, eb);
    chk("wrap_count", beats_a.size(), 32'd4);
    if (beats_a.size() == 4) begin
      chk("wrap_fe", {24'd0, beats_a[0]}, 32'h11);
      chk("wrap_ff", {24'd0, beats_a[1]}, 32'h22);
      chk("wrap_00", {24'd0, beats_a[2]}, 32'h33);
      chk("wrap_01", {24'd0, beats_a[3]}, 32'h44);
    end
    chk("wrap_err_b", {31'd0, eb}, 32'd1);

    // req dropped and a stray start during the first WAIT of a burst
    do_txn(2'b10, 8'h10, 8'h00, 1, 1, ra, ea, rb, eb);
    last_a = ra;
    @(negedge clk);
    chk("drop_gnt_a", {31'd0, gnt_a}, 32'd0);
    chk("drop_gnt_b", {31'd0, gnt_b}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("idle_rdy_a", {31'd0, rdy_a}, 32'd0);
      chk("rdata_hold_a", {24'd0, rdata_a}, {24'd0, last_a});
      @(negedge clk);
    end
    do_txn(2'b00, 8'h20, 8'h00, -1, -1, ra, ea, rb, eb);

    // Randomized traffic
    for (int i = 0; i < 150; i++)
      do_txn(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), -1, -1, ra, ea, rb, eb);

    // Async reset in the middle of a burst
    req = 1'b1;
    for (int t = 0; t < 20 && !(gnt_a && gnt_b); t++) @(negedge clk);
    mode = 2'b10; addr = 8'h30; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rdy_a", {31'd0, rdy_a}, 32'd0);
    chk("midrst_gnt_a", {31'd0, gnt_a}, 32'd0);
    chk("midrst_err_a", {31'd0, err_a}, 32'd0);
    chk("midrst_rdata_a", {24'd0, rdata_a}, 32'd0);
    chk("midrst_gnt_b", {31'd0, gnt_b}, 32'd0);
    chk("midrst_rdy_b", {31'd0, rdy_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt_a", {31'd0, gnt_a}, 32'd1);
    chk("post_rst_rdy_a", {31'd0, rdy_a}, 32'd0);
    do_txn(2'b00, 8'h30, 8'h00, -1, -1, ra, ea, rb, eb);
    chk("post_rst_rd_a", {24'd0, ra}, {24'd0, ma[8'h30]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
